// File: rtl/hack_mem_io.sv
// hack_mem_io: data memory and memory-mapped I/O stage behind the Hack CPU.
//   Address map: 0x0000-0x3FFF data RAM, 0x4000-0x5FFF screen, 0x6000 keyboard.
//   Screen writes update a local shadow RAM (for read-back) and are queued in a
//   FIFO towards the display port (scr_valid/scr_ready handshake).
// Ports:
//   clk50m             system clock, rising edge
//   rst                synchronous reset, active-high
//   writeM/outM/addressM  CPU write strobe, write data, address
//   inM                combinational read data for addressM
//   stall              CPU must hold: screen write while queue is full
//   scr_valid/scr_addr/scr_data/scr_ready  display queue head and handshake
//   kbd_code           live key code, registered once per cycle
module hack_mem_io #(
  parameter int unsigned DW         = 16,
  parameter int unsigned AW         = 15,
  parameter int unsigned FIFO_DEPTH = 8
) (
  input  logic          clk50m,
  input  logic          rst,
  input  logic          writeM,
  input  logic [DW-1:0] outM,
  input  logic [AW-1:0] addressM,
  output logic [DW-1:0] inM,
  output logic          stall,
  output logic          scr_valid,
  output logic [12:0]   scr_addr,
  output logic [DW-1:0] scr_data,
  input  logic          scr_ready,
  input  logic [DW-1:0] kbd_code
);

  localparam int unsigned PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned EW = 13 + DW;

  logic [DW-1:0] ram_mem  [0:16383];
  logic [DW-1:0] shadow_mem [0:8191];
  logic [EW-1:0] fifo_mem [0:FIFO_DEPTH-1];

  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q,  count_d;
  logic [DW-1:0] kbd_q,    kbd_d;

  logic is_ram, is_scr, is_kbd;
  logic full, empty;
  logic ram_we, push, pop;

  always_comb begin
    is_ram = ~addressM[14];
    is_scr = (addressM[14:13] == 2'b10);
    is_kbd = (addressM == AW'(15'h6000));
  end

  always_comb begin
    full  = (count_q == CW'(FIFO_DEPTH));
    empty = (count_q == '0);
  end

  // stall looks only at the registered full flag, so a pop in the same cycle
  // does not release it; the held write is accepted one cycle later.
  always_comb begin
    stall  = writeM & is_scr & full;
    ram_we = writeM & is_ram & ~rst;
    push   = writeM & is_scr & ~full & ~rst;
    pop    = ~empty & scr_ready & ~rst;
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    kbd_d    = kbd_code;
    if (push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk50m) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      kbd_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      kbd_q    <= kbd_d;
    end
  end

  // Storage arrays are never reset; contents survive rst.
  always_ff @(posedge clk50m) begin
    if (ram_we) ram_mem[addressM[13:0]] <= outM;
    if (push) begin
      shadow_mem[addressM[12:0]] <= outM;
      fifo_mem[wr_ptr_q]         <= {addressM[12:0], outM};
    end
  end

  always_comb begin
    inM = '0;
    if (is_ram)      inM = ram_mem[addressM[13:0]];
    else if (is_scr) inM = shadow_mem[addressM[12:0]];
    else if (is_kbd) inM = kbd_q;
  end

  always_comb begin
    scr_valid = ~empty;
    scr_addr  = fifo_mem[rd_ptr_q][EW-1:DW];
    scr_data  = fifo_mem[rd_ptr_q][DW-1:0];
  end

endmodule

// File: tb/tb_hack_mem_io.sv
module tb_hack_mem_io;

  localparam int unsigned DEPTH = 8;

  logic        clk50m = 1'b0;
  logic        rst = 1'b1;
  logic        writeM = 1'b0;
  logic [15:0] outM = '0;
  logic [14:0] addressM = '0;
  logic [15:0] inM;
  logic        stall;
  logic        scr_valid;
  logic [12:0] scr_addr;
  logic [15:0] scr_data;
  logic        scr_ready = 1'b0;
  logic [15:0] kbd_code = '0;

  int unsigned total = 0;
  int unsigned bad = 0;
  int unsigned delivered = 0;
  int unsigned mcnt = 0;
  logic [28:0] exp_q[$];

  hack_mem_io #(.DW(16), .AW(15), .FIFO_DEPTH(DEPTH)) dut (
    .clk50m(clk50m), .rst(rst), .writeM(writeM), .outM(outM),
    .addressM(addressM), .inM(inM), .stall(stall), .scr_valid(scr_valid),
    .scr_addr(scr_addr), .scr_data(scr_data), .scr_ready(scr_ready),
    .kbd_code(kbd_code)
  );

  always #5 clk50m = ~clk50m;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic is_scr(input logic [14:0] a);
    return a[14:13] == 2'b10;
  endfunction

  // Reference model: queue occupancy and expected delivery order, advanced
  // on every falling edge from the bench-driven inputs.
  initial begin
    logic        push_m, pop_m;
    logic [28:0] e;
    forever begin
      @(negedge clk50m);
      check("stall", {31'd0, stall}, {31'd0, writeM && is_scr(addressM) && mcnt == DEPTH});
      if (!rst) check("scr_valid", {31'd0, scr_valid}, {31'd0, mcnt != 0});
      push_m = !rst && writeM && is_scr(addressM) && mcnt != DEPTH;
      pop_m  = !rst && scr_ready && mcnt != 0;
      if (pop_m) begin
        e = exp_q.pop_front();
        check("head_addr", {19'd0, scr_addr}, {19'd0, e[28:16]});
        check("head_data", {16'd0, scr_data}, {16'd0, e[15:0]});
        delivered++;
      end
      if (push_m) exp_q.push_back({addressM[12:0], outM});
      if (rst) begin
        mcnt = 0;
        exp_q.delete();
      end else begin
        mcnt = mcnt + (push_m ? 1 : 0) - (pop_m ? 1 : 0);
      end
    end
  end

  task automatic wr(input logic [14:0] a, input logic [15:0] d);
    writeM = 1'b1; addressM = a; outM = d;
    @(posedge clk50m); #1;
    writeM = 1'b0;
  endtask

  task automatic rd(input string tag, input logic [14:0] a, input logic [15:0] exp);
    writeM = 1'b0; addressM = a;
    #1;
    check(tag, {16'd0, inM}, {16'd0, exp});
  endtask

  task automatic idle(input int unsigned n);
    repeat (n) begin
      @(posedge clk50m); #1;
    end
  endtask

  task automatic drain();
    int unsigned guard = 0;
    scr_ready = 1'b1;
    while (scr_valid && guard < 50) begin
      @(posedge clk50m); #1;
      guard++;
    end
    if (guard >= 50) check("drain_timeout", 32'd1, 32'd0);
    idle(1);
    scr_ready = 1'b0;
  endtask

  initial begin
    int unsigned d0;
    idle(2);
    rst = 1'b0;
    check("rst_valid", {31'd0, scr_valid}, 32'd0);
    check("rst_stall", {31'd0, stall}, 32'd0);

    // RAM write / read-back, no same-cycle bypass
    wr(15'h0005, 16'h1234);
    rd("ram_rd", 15'h0005, 16'h1234);
    check("ram_valid", {31'd0, scr_valid}, 32'd0);
    writeM = 1'b1; outM = 16'h5678; #1;
    check("ram_nobypass", {16'd0, inM}, 32'h1234);
    @(posedge clk50m); #1; writeM = 1'b0;
    rd("ram_rd2", 15'h0005, 16'h5678);

    // Screen write, head held while not ready
    wr(15'h4010, 16'hBEEF);
    check("scr_v", {31'd0, scr_valid}, 32'd1);
    check("scr_a", {19'd0, scr_addr}, 32'h010);
    check("scr_d", {16'd0, scr_data}, 32'hBEEF);
    rd("scr_rd", 15'h4010, 16'hBEEF);
    for (int i = 0; i < 5; i++) begin
      idle(1);
      check("hold_a", {19'd0, scr_addr}, 32'h010);
      check("hold_d", {16'd0, scr_data}, 32'hBEEF);
    end
    wr(15'h4200, 16'h1111);
    drain();

    // Fill to full, 9th write stalls and leaves shadow untouched
    d0 = delivered;
    for (int i = 0; i < 8; i++) wr(15'h4100 + 15'(i), 16'hA000 + 16'(i));
    writeM = 1'b1; addressM = 15'h4200; outM = 16'h9999; #1;
    check("full_stall", {31'd0, stall}, 32'd1);
    check("full_shadow", {16'd0, inM}, 32'h1111);
    @(posedge clk50m); #1;
    scr_ready = 1'b1; #1;
    check("pop_stall", {31'd0, stall}, 32'd1);
    @(posedge clk50m); #1;
    scr_ready = 1'b0; #1;
    check("accept_stall", {31'd0, stall}, 32'd0);
    @(posedge clk50m); #1;
    writeM = 1'b0;
    rd("accept_shadow", 15'h4200, 16'h9999);
    drain();
    check("nine_delivered", delivered - d0, 32'd9);

    // Simultaneous push+pop at count 3 keeps count 3
    for (int i = 0; i < 3; i++) wr(15'h4300 + 15'(i), 16'hC000 + 16'(i));
    scr_ready = 1'b1;
    wr(15'h4303, 16'hC003);
    scr_ready = 1'b0;
    for (int i = 0; i < 5; i++) wr(15'h4304 + 15'(i), 16'hC004 + 16'(i));
    writeM = 1'b1; addressM = 15'h4310; outM = 16'hC010; #1;
    check("cnt3_stall", {31'd0, stall}, 32'd1);
    writeM = 1'b0;
    drain();

    // 20 writes across pointer wrap with random display backpressure
    for (int i = 0; i < 20; i++) begin
      int unsigned tries = 0;
      logic        st;
      writeM = 1'b1; addressM = 15'h5000 + 15'(i); outM = 16'(32'h7000 + i * 37);
      do begin
        scr_ready = 1'($urandom_range(0, 1)); #1;
        st = stall;
        @(posedge clk50m); #1;
        tries++;
      end while (st && tries < 30);
      if (st) check("wrap_timeout", 32'd1, 32'd0);
    end
    writeM = 1'b0;
    drain();
    check("q_empty", exp_q.size(), 32'd0);

    // Keyboard
    kbd_code = 16'h0041;
    idle(1);
    rd("kbd_rd", 15'h6000, 16'h0041);
    rd("unmapped_rd", 15'h6001, 16'h0000);
    wr(15'h6000, 16'hFFFF);
    rd("kbd_wr_ignored", 15'h6000, 16'h0041);

    // Reset with 4 entries queued and a screen write during reset
    wr(15'h4000, 16'h2222);
    drain();
    for (int i = 0; i < 4; i++) wr(15'h4400 + 15'(i), 16'hD000 + 16'(i));
    check("pre_rst_valid", {31'd0, scr_valid}, 32'd1);
    rst = 1'b1;
    wr(15'h4000, 16'h7777);
    rst = 1'b0;
    check("post_rst_valid", {31'd0, scr_valid}, 32'd0);
    check("post_rst_stall", {31'd0, stall}, 32'd0);
    rd("rst_shadow", 15'h4000, 16'h2222);
    rd("rst_ram", 15'h0005, 16'h5678);
    idle(2);
    check("rst_no_push", {31'd0, scr_valid}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1);
  end

endmodule
